// File: rtl/aha_sram_to_axi.sv
// Single-outstanding bridge from a native SRAM-style request/response port to a
// 64-bit AXI4 manager port. Every request becomes one LEN=0, 8-byte AXI beat.
module aha_sram_to_axi #(
  parameter logic [3:0] AxiId    = 4'h0,
  parameter logic [3:0] AxiCache = 4'b0011,
  parameter logic [2:0] AxiProt  = 3'b010
) (
  input  logic        aclk_i,
  input  logic        aresetn_i,
  // Native request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wstrb_i,
  // Native response
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // AW
  output logic [3:0]  m_axi_awid_o,
  output logic [31:0] m_axi_awaddr_o,
  output logic [7:0]  m_axi_awlen_o,
  output logic [2:0]  m_axi_awsize_o,
  output logic [1:0]  m_axi_awburst_o,
  output logic        m_axi_awlock_o,
  output logic [3:0]  m_axi_awcache_o,
  output logic [2:0]  m_axi_awprot_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  // W
  output logic [63:0] m_axi_wdata_o,
  output logic [7:0]  m_axi_wstrb_o,
  output logic        m_axi_wlast_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  // B
  input  logic [3:0]  m_axi_bid_i,
  input  logic [1:0]  m_axi_bresp_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  // AR
  output logic [3:0]  m_axi_arid_o,
  output logic [31:0] m_axi_araddr_o,
  output logic [7:0]  m_axi_arlen_o,
  output logic [2:0]  m_axi_arsize_o,
  output logic [1:0]  m_axi_arburst_o,
  output logic        m_axi_arlock_o,
  output logic [3:0]  m_axi_arcache_o,
  output logic [2:0]  m_axi_arprot_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  // R
  input  logic [3:0]  m_axi_rid_i,
  input  logic [63:0] m_axi_rdata_i,
  input  logic [1:0]  m_axi_rresp_i,
  input  logic        m_axi_rlast_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWr     = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdAddr = 3'd3;
  localparam logic [2:0] StRdData = 3'd4;
  localparam logic [2:0] StRsp    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [28:0] addr_q, addr_d;  // 8-byte word address; low bits never leave the bridge
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        req_ready_q, req_ready_d;

  // IDs, RLAST and the low response bit carry no information for a single-beat bridge.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid_i, m_axi_rid_i, m_axi_rlast_i, m_axi_bresp_i[0],
                           m_axi_rresp_i[0], req_addr_i[2:0]};

  // Constant AXI attributes and state-decoded handshake outputs.
  assign m_axi_awid_o    = AxiId;
  assign m_axi_awaddr_o  = {addr_q, 3'b000};
  assign m_axi_awlen_o   = 8'd0;
  assign m_axi_awsize_o  = 3'd3;
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awlock_o  = 1'b0;
  assign m_axi_awcache_o = AxiCache;
  assign m_axi_awprot_o  = AxiProt;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wlast_o   = 1'b1;
  assign m_axi_arid_o    = AxiId;
  assign m_axi_araddr_o  = {addr_q, 3'b000};
  assign m_axi_arlen_o   = 8'd0;
  assign m_axi_arsize_o  = 3'd3;
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arlock_o  = 1'b0;
  assign m_axi_arcache_o = AxiCache;
  assign m_axi_arprot_o  = AxiProt;

  assign m_axi_awvalid_o = (state_q == StWr) && !aw_done_q;
  assign m_axi_wvalid_o  = (state_q == StWr) && !w_done_q;
  assign m_axi_bready_o  = (state_q == StWrResp);
  assign m_axi_arvalid_o = (state_q == StRdAddr);
  assign m_axi_rready_o  = (state_q == StRdData);
  assign rsp_valid_o     = (state_q == StRsp);
  assign rsp_rdata_o     = rdata_q;
  assign rsp_err_o       = err_q;
  // Registered so it reads 0 while reset is held and rises the first cycle after release.
  assign req_ready_o     = req_ready_q;

  // Next-state and datapath capture for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          addr_d    = req_addr_i[31:3];
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i ? StWr : StRdAddr;
        end
      end
      StWr: begin
        if (m_axi_awvalid_o && m_axi_awready_i) aw_done_d = 1'b1;
        if (m_axi_wvalid_o && m_axi_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)              state_d   = StWrResp;
      end
      StWrResp: begin
        if (m_axi_bvalid_i) begin
          err_d   = m_axi_bresp_i[1];
          rdata_d = 64'd0;
          state_d = StRsp;
        end
      end
      StRdAddr: begin
        if (m_axi_arready_i) state_d = StRdData;
      end
      StRdData: begin
        if (m_axi_rvalid_i) begin
          err_d   = m_axi_rresp_i[1];
          rdata_d = m_axi_rdata_i;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready_q <= req_ready_d;
    end
  end

endmodule
